// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM and its output decoder.
package ctrl_pkg;

    // State codes, also exported on the debug state port.
    localparam logic [3:0] ST_FETCH    = 4'd0;
    localparam logic [3:0] ST_DECODE   = 4'd1;
    localparam logic [3:0] ST_MEM_ADDR = 4'd2;
    localparam logic [3:0] ST_MEM_RD   = 4'd3;
    localparam logic [3:0] ST_MEM_WB   = 4'd4;
    localparam logic [3:0] ST_MEM_WR   = 4'd5;
    localparam logic [3:0] ST_R_EXE    = 4'd6;
    localparam logic [3:0] ST_R_WB     = 4'd7;
    localparam logic [3:0] ST_BEQ      = 4'd8;
    localparam logic [3:0] ST_JMP      = 4'd9;
    localparam logic [3:0] ST_I_EXE    = 4'd10;
    localparam logic [3:0] ST_I_WB     = 4'd11;

    typedef enum logic [3:0] {
        StFetch   = ST_FETCH,
        StDecode  = ST_DECODE,
        StMemAddr = ST_MEM_ADDR,
        StMemRd   = ST_MEM_RD,
        StMemWb   = ST_MEM_WB,
        StMemWr   = ST_MEM_WR,
        StRExe    = ST_R_EXE,
        StRWb     = ST_R_WB,
        StBeq     = ST_BEQ,
        StJmp     = ST_JMP,
        StIExe    = ST_I_EXE,
        StIWb     = ST_I_WB
    } state_e;

    // Opcode field IR[31:26].
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    // ALU control requests.
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    // PC source mux selects.
    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    // ALU B operand mux selects.
    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

endpackage

// File: rtl/ctrl_decode.sv
// Pure combinational decode of the current FSM state into the datapath control word.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [3:0] state,
    input  logic       mem_ready,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source
);

    // Moore decode per state; only the fetch load enables look at mem_ready.
    always_comb begin
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_REG;
        alu_op        = ALU_ADD;
        pc_source     = PC_ALU;
        unique case (state)
            ST_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                // IR and PC+4 only commit once the instruction word is actually back.
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            ST_DECODE: begin
                alu_src_b = SRCB_IMM_SH;
            end
            ST_MEM_ADDR, ST_I_EXE: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            ST_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            ST_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            ST_MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            ST_R_EXE: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
            end
            ST_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            ST_BEQ: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PC_ALUOUT;
            end
            ST_JMP: begin
                pc_write  = 1'b1;
                pc_source = PC_JUMP;
            end
            ST_I_WB: begin
                reg_write = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Sequencing FSM for the multi-cycle MIPS datapath, with sticky illegal flag and retire counter.
module multi_cycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             mem_to_reg,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic [3:0]       state,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_cnt
);

    state_e           state_q, state_d;
    logic             is_store_q, is_store_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             retire;

    // Next-state, opcode capture, illegal flag and retire counting.
    always_comb begin
        state_d    = state_q;
        is_store_d = is_store_q;
        illegal_d  = illegal_q;
        retire     = 1'b0;
        unique case (state_q)
            StFetch: if (mem_ready) state_d = StDecode;
            StDecode: begin
                unique case (opcode)
                    OP_LW: begin
                        state_d    = StMemAddr;
                        is_store_d = 1'b0;
                    end
                    OP_SW: begin
                        state_d    = StMemAddr;
                        is_store_d = 1'b1;
                    end
                    OP_R:    state_d = StRExe;
                    OP_BEQ:  state_d = StBeq;
                    OP_J:    state_d = StJmp;
                    OP_ADDI: state_d = StIExe;
                    default: begin
                        state_d   = StFetch;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            // lw/sw are told apart from the opcode latched in decode, not the live IR field.
            StMemAddr: state_d = is_store_q ? StMemWr : StMemRd;
            StMemRd:   if (mem_ready) state_d = StMemWb;
            StMemWr: begin
                if (mem_ready) begin
                    state_d = StFetch;
                    retire  = 1'b1;
                end
            end
            StRExe: state_d = StRWb;
            StIExe: state_d = StIWb;
            StMemWb, StRWb, StBeq, StJmp, StIWb: begin
                state_d = StFetch;
                retire  = 1'b1;
            end
            default: state_d = StFetch;
        endcase
        cnt_d = retire ? cnt_q + CNT_W'(1) : cnt_q;
    end

    // State and status registers; reset aborts any in-flight instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StFetch;
            is_store_q <= 1'b0;
            illegal_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            is_store_q <= is_store_d;
            illegal_q  <= illegal_d;
            cnt_q      <= cnt_d;
        end
    end

    assign state     = state_q;
    assign illegal   = illegal_q;
    assign instr_cnt = cnt_q;

    ctrl_decode u_decode (
        .state         (state_q),
        .mem_ready     (mem_ready),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_to_reg    (mem_to_reg),
        .reg_dst       (reg_dst),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_source     (pc_source)
    );

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed self-checking bench for multi_cycle_ctrl (4-bit counter to reach wrap quickly).
module tb_multi_cycle_ctrl;

    localparam logic [5:0] OPC_R    = 6'b000000;
    localparam logic [5:0] OPC_LW   = 6'b100011;
    localparam logic [5:0] OPC_SW   = 6'b101011;
    localparam logic [5:0] OPC_BEQ  = 6'b000100;
    localparam logic [5:0] OPC_J    = 6'b000010;
    localparam logic [5:0] OPC_ADDI = 6'b001000;
    localparam logic [5:0] OPC_BAD  = 6'b111111;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic       mem_ready = 1'b1;
    logic       ir_write, pc_write, pc_write_cond, i_or_d, mem_read, mem_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state;
    logic       illegal;
    logic [3:0] instr_cnt;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [3:0] exp_cnt = 4'd0;

    always #5 clk = ~clk;

    multi_cycle_ctrl #(.CNT_W(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_to_reg    (mem_to_reg),
        .reg_dst       (reg_dst),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_source     (pc_source),
        .state         (state),
        .illegal       (illegal),
        .instr_cnt     (instr_cnt)
    );

    task automatic test_reset;
        rst_n = 1'b0; mem_ready = 1'b1; opcode = OPC_R;
        #3;
        n_tests += 5;
        if (state !== 4'd0) begin n_fail++; $display("FAIL reset_state got %0d exp 0", state); end
        if (illegal !== 1'b0) begin n_fail++; $display("FAIL reset_illegal got %b exp 0", illegal); end
        if (instr_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_cnt got %0d exp 0", instr_cnt); end
        if ({ir_write, pc_write, mem_read} !== 3'b111) begin
            n_fail++; $display("FAIL reset_fetch_rdy got %b exp 111", {ir_write, pc_write, mem_read});
        end
        if ({mem_write, reg_write, pc_write_cond, alu_src_b} !== 5'b00001) begin
            n_fail++;
            $display("FAIL reset_fetch_misc got %b exp 00001",
                     {mem_write, reg_write, pc_write_cond, alu_src_b});
        end
        mem_ready = 1'b0;
        #1;
        n_tests++;
        if ({ir_write, pc_write, mem_read} !== 3'b001) begin
            n_fail++; $display("FAIL reset_fetch_gated got %b exp 001", {ir_write, pc_write, mem_read});
        end
        @(negedge clk);
        rst_n = 1'b1; mem_ready = 1'b1; exp_cnt = 4'd0;
    endtask

    task automatic test_reset_mid;
        opcode = OPC_R; mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        n_tests++;
        if (state !== 4'd6) begin n_fail++; $display("FAIL rmid_in_rexe got %0d exp 6", state); end
        #1 rst_n = 1'b0;
        #1;
        n_tests += 3;
        if (state !== 4'd0) begin n_fail++; $display("FAIL rmid_state got %0d exp 0", state); end
        if (instr_cnt !== exp_cnt) begin
            n_fail++; $display("FAIL rmid_cnt got %0d exp %0d", instr_cnt, exp_cnt);
        end
        if ({ir_write, pc_write, reg_write, mem_write, pc_write_cond} !== 5'b11000) begin
            n_fail++;
            $display("FAIL rmid_enables got %b exp 11000",
                     {ir_write, pc_write, reg_write, mem_write, pc_write_cond});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_r_type;
        logic [3:0] st [0:3];
        logic [1:0] rw [0:3];
        st = '{4'd0, 4'd1, 4'd6, 4'd7};
        rw = '{2'b00, 2'b00, 2'b00, 2'b11};
        for (int c = 0; c < 4; c++) begin
            opcode = OPC_R; mem_ready = 1'b1;
            #1;
            n_tests += 2;
            if (state !== st[c]) begin
                n_fail++; $display("FAIL r_state c%0d got %0d exp %0d", c, state, st[c]);
            end
            if ({reg_write, reg_dst} !== rw[c]) begin
                n_fail++; $display("FAIL r_regwr c%0d got %b exp %b", c, {reg_write, reg_dst}, rw[c]);
            end
            if (c == 2) begin
                n_tests++;
                if (alu_op !== 2'b10) begin n_fail++; $display("FAIL r_aluop got %b exp 10", alu_op); end
            end
            @(negedge clk);
        end
        exp_cnt = exp_cnt + 4'd1;
        #1;
        n_tests++;
        if (instr_cnt !== exp_cnt) begin n_fail++; $display("FAIL r_cnt got %0d exp %0d", instr_cnt, exp_cnt); end
    endtask

    task automatic test_lw_wait;
        logic [3:0] st [0:6];
        logic       mr [0:6];
        logic [1:0] rd [0:6];
        st = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd4};
        mr = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        // {mem_read, mem_to_reg}
        rd = '{2'b10, 2'b00, 2'b00, 2'b10, 2'b10, 2'b10, 2'b01};
        for (int c = 0; c < 7; c++) begin
            opcode = OPC_LW; mem_ready = mr[c];
            #1;
            n_tests += 2;
            if (state !== st[c]) begin
                n_fail++; $display("FAIL lw_state c%0d got %0d exp %0d", c, state, st[c]);
            end
            if ({mem_read, mem_to_reg} !== rd[c]) begin
                n_fail++; $display("FAIL lw_rd c%0d got %b exp %b", c, {mem_read, mem_to_reg}, rd[c]);
            end
            @(negedge clk);
        end
        mem_ready = 1'b1;
        exp_cnt = exp_cnt + 4'd1;
        #1;
        n_tests += 2;
        if (state !== 4'd0) begin n_fail++; $display("FAIL lw_end_state got %0d exp 0", state); end
        if (instr_cnt !== exp_cnt) begin n_fail++; $display("FAIL lw_cnt got %0d exp %0d", instr_cnt, exp_cnt); end
    endtask

    task automatic test_back_to_back;
        logic [3:0] st [0:6];
        logic [5:0] op [0:6];
        logic [3:0] wv [0:6];
        st = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0, 4'd1, 4'd8};
        op = '{OPC_SW, OPC_SW, OPC_SW, OPC_SW, OPC_BEQ, OPC_BEQ, OPC_BEQ};
        // {mem_write, pc_write_cond, pc_source}
        wv = '{4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b0101};
        for (int c = 0; c < 7; c++) begin
            opcode = op[c]; mem_ready = 1'b1;
            #1;
            n_tests += 3;
            if (state !== st[c]) begin
                n_fail++; $display("FAIL b2b_state c%0d got %0d exp %0d", c, state, st[c]);
            end
            if ({mem_write, pc_write_cond, pc_source} !== wv[c]) begin
                n_fail++;
                $display("FAIL b2b_ctl c%0d got %b exp %b", c, {mem_write, pc_write_cond, pc_source}, wv[c]);
            end
            if (mem_read && mem_write) begin
                n_fail++; $display("FAIL b2b_rw_excl c%0d got both high exp not both", c);
            end
            if (c == 3) exp_cnt = exp_cnt + 4'd1;
            @(negedge clk);
        end
        exp_cnt = exp_cnt + 4'd1;
        #1;
        n_tests++;
        if (instr_cnt !== exp_cnt) begin n_fail++; $display("FAIL b2b_cnt got %0d exp %0d", instr_cnt, exp_cnt); end
    endtask

    task automatic test_addi;
        logic [3:0] st [0:3];
        logic [3:0] cv [0:3];
        st = '{4'd0, 4'd1, 4'd10, 4'd11};
        // {alu_src_a, alu_src_b, reg_write}
        cv = '{4'b0010, 4'b0110, 4'b1100, 4'b0001};
        for (int c = 0; c < 4; c++) begin
            opcode = OPC_ADDI; mem_ready = 1'b1;
            #1;
            n_tests += 2;
            if (state !== st[c]) begin
                n_fail++; $display("FAIL addi_state c%0d got %0d exp %0d", c, state, st[c]);
            end
            if ({alu_src_a, alu_src_b, reg_write} !== cv[c]) begin
                n_fail++;
                $display("FAIL addi_ctl c%0d got %b exp %b", c, {alu_src_a, alu_src_b, reg_write}, cv[c]);
            end
            @(negedge clk);
        end
        exp_cnt = exp_cnt + 4'd1;
        #1;
        n_tests++;
        if (instr_cnt !== exp_cnt) begin n_fail++; $display("FAIL addi_cnt got %0d exp %0d", instr_cnt, exp_cnt); end
    endtask

    task automatic test_illegal;
        logic [3:0] st [0:4];
        logic [5:0] op [0:4];
        logic [2:0] jv [0:4];
        st = '{4'd0, 4'd1, 4'd0, 4'd1, 4'd9};
        op = '{OPC_BAD, OPC_BAD, OPC_J, OPC_J, OPC_J};
        // {pc_write, pc_source}
        jv = '{3'b100, 3'b000, 3'b100, 3'b000, 3'b110};
        for (int c = 0; c < 5; c++) begin
            opcode = op[c]; mem_ready = 1'b1;
            #1;
            n_tests += 2;
            if (state !== st[c]) begin
                n_fail++; $display("FAIL ill_state c%0d got %0d exp %0d", c, state, st[c]);
            end
            if ({pc_write, pc_source} !== jv[c]) begin
                n_fail++; $display("FAIL ill_jctl c%0d got %b exp %b", c, {pc_write, pc_source}, jv[c]);
            end
            if (c == 2) begin
                n_tests += 2;
                if (illegal !== 1'b1) begin n_fail++; $display("FAIL ill_set got %b exp 1", illegal); end
                if (instr_cnt !== exp_cnt) begin
                    n_fail++; $display("FAIL ill_nocount got %0d exp %0d", instr_cnt, exp_cnt);
                end
            end
            @(negedge clk);
        end
        exp_cnt = exp_cnt + 4'd1;
        #1;
        n_tests += 2;
        if (illegal !== 1'b1) begin n_fail++; $display("FAIL ill_sticky got %b exp 1", illegal); end
        if (instr_cnt !== exp_cnt) begin n_fail++; $display("FAIL ill_jcnt got %0d exp %0d", instr_cnt, exp_cnt); end
    endtask

    task automatic test_wrap;
        for (int k = 0; k < 20 && exp_cnt != 4'd0; k++) begin
            opcode = OPC_J; mem_ready = 1'b1;
            repeat (3) @(negedge clk);
            exp_cnt = exp_cnt + 4'd1;
            #1;
            n_tests++;
            if (instr_cnt !== exp_cnt) begin
                n_fail++; $display("FAIL wrap_step k%0d got %0d exp %0d", k, instr_cnt, exp_cnt);
            end
        end
        n_tests++;
        if (instr_cnt !== 4'd0) begin n_fail++; $display("FAIL wrap_zero got %0d exp 0", instr_cnt); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_reset_mid();
        test_r_type();
        test_lw_wait();
        test_back_to_back();
        test_addi();
        test_illegal();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Hard time limit in case the sequencing ever stalls.
    initial begin
        #50000;
        $display("FAIL timeout got no finish exp finish by 50000");
        $fatal(1, "timeout");
    end

endmodule
